// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: load/store request and single-cycle response bus for the data memory.
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_w_en;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
    modport master (
        output req_valid, req_w_en, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
    modport slave (
        input  req_valid, req_w_en, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: word-addressed data memory with WAIT_CYCLES wait states; DMEM_ALIGN_CHECK_EN flags misaligned accesses.
module data_mem_responder #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 1
) (
    input logic                 clk,
    input logic                 rst,
    data_mem_responder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t            r_state, w_next;
    logic [3:0]        r_cnt;
    logic [ADDR_W-1:0] r_idx;
    logic [31:0]       r_wdata, r_rdata;
    logic              r_w_en, r_mis, w_mis, w_take, w_access, w_unused;
    logic [31:0]       r_mem [2**ADDR_W];
`ifdef DMEM_ALIGN_CHECK_EN
    assign w_mis = |bus.req_addr[1:0];
`else
    assign w_mis = 1'b0;
`endif
    assign w_unused = ^bus.req_addr;
    assign w_take   = r_state == IDLE && bus.req_valid;
    assign w_access = r_state == WAIT && r_cnt == 4'd0;
    always_comb begin
        w_next = w_take ? WAIT : w_access ? RESP : (r_state == RESP) ? IDLE : r_state;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_w_en  <= 1'b0;
            r_mis   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            if (w_take) begin
                r_cnt   <= 4'(WAIT_CYCLES);
                r_idx   <= bus.req_addr[ADDR_W+1:2];
                r_wdata <= bus.req_wdata;
                r_w_en  <= bus.req_w_en;
                r_mis   <= w_mis;
            end else if (r_state == WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_access) r_rdata <= r_mis ? '0 : r_w_en ? r_wdata : r_mem[r_idx];
        end
    end
    // array is deliberately unreset; reset only blocks a pending store
    always_ff @(posedge clk) begin
        if (w_access && r_w_en && !r_mis && !rst) r_mem[r_idx] <= r_wdata;
    end
    assign bus.req_ready = r_state == IDLE;
    assign bus.busy      = r_state != IDLE;
    assign bus.rsp_valid = r_state == RESP;
    assign bus.rsp_rdata = r_rdata;
    assign bus.rsp_err   = r_state == RESP && r_mis;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed and random load/store checks on three responders (WAIT_CYCLES 1, 0, 3).
module tb_data_mem_responder;
    localparam int WC [3] = '{1, 0, 3};
`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic        w_en = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    int          sel = 0;
    logic        ready_a [3];
    logic        rvalid_a [3];
    logic        err_a [3];
    logic        busy_a [3];
    logic [31:0] rdata_a [3];
    logic [31:0] model [3][256];
    bit          known [3][256];
    int          total = 0;
    int          passed = 0;
    always #5 clk = ~clk;
    for (genvar g = 0; g < 3; g++) begin : g_dut
        data_mem_responder_if bus ();
        data_mem_responder #(.ADDR_W(8), .WAIT_CYCLES(g == 0 ? 1 : g == 1 ? 0 : 3)) u_dut (
            .clk(clk), .rst(rst), .bus(bus.slave)
        );
        assign bus.req_valid = valid && sel == g;
        assign bus.req_w_en  = w_en;
        assign bus.req_addr  = addr;
        assign bus.req_wdata = wdata;
        assign ready_a[g]    = bus.req_ready;
        assign rvalid_a[g]   = bus.rsp_valid;
        assign err_a[g]      = bus.rsp_err;
        assign busy_a[g]     = bus.busy;
        assign rdata_a[g]    = bus.rsp_rdata;
    end
    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s dut%0d: got 0x%08h expected 0x%08h", tag, sel, obs, exp);
    endtask
    task automatic wait_rsp(output int lat);
        lat = 999;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (rvalid_a[sel]) begin
                lat = n;
                break;
            end
        end
    endtask
    task automatic txn(logic we, logic [31:0] a, logic [31:0] d);
        logic [31:0] er;
        logic        ee;
        int          lat;
        int          idx;
        bit          mis;
        idx = int'(a[9:2]);
        mis = ALIGN && a[1:0] != 2'b00;
        ee  = mis;
        er  = mis ? 32'h0 : we ? d : model[sel][idx];
        if (!mis && we) begin
            model[sel][idx] = d;
            known[sel][idx] = 1'b1;
        end
        @(negedge clk);
        check("ready_before", 32'(ready_a[sel]), 1);
        valid = 1'b1; w_en = we; addr = a; wdata = d;
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0; w_en = 1'($urandom); addr = $urandom; wdata = $urandom;
        check("busy", 32'(busy_a[sel]), 1);
        wait_rsp(lat);
        check("latency", 32'(lat), 32'(WC[sel] + 1));
        check("rdata", rdata_a[sel], er);
        check("err", 32'(err_a[sel]), 32'(ee));
        @(negedge clk);
        check("rvalid_drop", 32'(rvalid_a[sel]), 0);
        check("err_drop", 32'(err_a[sel]), 0);
        check("ready_after", 32'(ready_a[sel]), 1);
        check("rdata_hold", rdata_a[sel], er);
    endtask
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
    initial begin
        int          gap;
        int          lat;
        logic        seen;
        logic [31:0] r;
        logic [7:0]  idx;
        logic [1:0]  lo;
        logic        we;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            sel = g;
            check("rst_ready", 32'(ready_a[g]), 1);
            check("rst_busy", 32'(busy_a[g]), 0);
            check("rst_rvalid", 32'(rvalid_a[g]), 0);
            check("rst_rdata", rdata_a[g], 0);
            check("rst_err", 32'(err_a[g]), 0);
        end
        sel = 0;
        txn(1'b1, 32'h10, 32'hDEADBEEF);
        txn(1'b0, 32'h10, 32'h0);
        check("load_deadbeef", rdata_a[0], 32'hDEADBEEF);
        sel = 1;
        @(negedge clk);
        valid = 1'b1; w_en = 1'b1; addr = 32'h0; wdata = 32'h1;
        model[1][0] = 32'h1; model[1][255] = 32'h2;
        known[1][0] = 1'b1; known[1][255] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        addr = 32'h3FC; wdata = 32'h2;
        gap = 999;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (ready_a[1]) begin
                gap = n + 1;
                break;
            end
        end
        check("b2b_gap", 32'(gap), 3);
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        check("b2b_first_rdata", rdata_a[1], 32'h1);
        wait_rsp(lat);
        check("b2b_latency", 32'(lat), 1);
        check("b2b_second_rdata", rdata_a[1], 32'h2);
        txn(1'b0, 32'h0, 32'h0);
        txn(1'b0, 32'h3FC, 32'h0);
        sel = 0;
        txn(1'b1, 32'h400, 32'h55);
        txn(1'b0, 32'h000, 32'h0);
        check("wrap_load", rdata_a[0], 32'h55);
        sel = 2;
        txn(1'b1, 32'h20, 32'hA);
        @(negedge clk);
        valid = 1'b1; w_en = 1'b1; addr = 32'h20; wdata = 32'hB;
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        check("abort_busy", 32'(busy_a[2]), 1);
        rst = 1'b1;
        #1;
        check("async_rst_busy", 32'(busy_a[2]), 0);
        check("async_rst_ready", 32'(ready_a[2]), 1);
        seen = rvalid_a[2];
        repeat (4) begin
            @(negedge clk);
            seen = seen | rvalid_a[2];
        end
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen = seen | rvalid_a[2];
        end
        check("abort_no_rsp", 32'(seen), 0);
        txn(1'b0, 32'h20, 32'h0);
        check("abort_prior_value", rdata_a[2], 32'hA);
        sel = 0;
        txn(1'b1, 32'h20, 32'h33);
        txn(1'b1, 32'h21, 32'h77);
        txn(1'b0, 32'h20, 32'h0);
        check("align_load", rdata_a[0], ALIGN ? 32'h33 : 32'h77);
        for (int g = 0; g < 3; g++) begin
            sel = g;
            repeat (30) begin
                r   = $urandom;
                idx = 8'($urandom_range(0, 255));
                lo  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
                we  = !known[g][idx] || ($urandom_range(0, 1) == 1);
                txn(we, {r[31:10], idx, lo}, $urandom);
            end
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Word-addressed data memory that services the load/store requests issued by the pipeline's memory stage (STR writes, LDR reads). It accepts one request at a time over a valid/ready handshake, spends a parameterised number of wait cycles, performs the access, and returns a single-cycle response. `busy` feeds the pipeline stall select so the memory stage holds while an access is outstanding.

## Interface
Parameters:
- `ADDR_W`, 8: word-address width; memory holds 2^ADDR_W 32-bit words.
- `WAIT_CYCLES`, 1: extra access wait states, range 0–15.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder can accept a request.
- `req_w_en`  in  1  1 = store (STR), 0 = load (LDR); driven from the stage's `mem_w_en`.
- `req_addr`  in  32  byte address; word index = `req_addr[ADDR_W+1:2]`.
- `req_wdata`  in  32  store data.
- `rsp_valid`  out  1  one-cycle response pulse.
- `rsp_rdata`  out  32  load data. For a store, echoes the written word.
- `rsp_err`  out  1  misaligned-access flag; see Configuration.
- `busy`  out  1  request accepted and not yet responded (WAIT or RESP).

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - `req_ready`=1.
  - If `req_valid` is 1 at the edge (handshake), latch the following, load `cnt`=`WAIT_CYCLES`, and go to WAIT:
    - word index
    - `req_wdata`
    - `req_w_en`
    - the alignment result
- WAIT:
  - `req_ready`=0.
  - If `cnt`≠0, decrement `cnt`.
  - If `cnt`==0, perform the access at this edge and go to RESP:
    - store: `mem[idx]`←wdata, `rsp_rdata`←wdata.
    - load: `rsp_rdata`←`mem[idx]`.
- RESP:
  - `rsp_valid`=1 and `req_ready`=0 for exactly one cycle.
  - Next edge: go to IDLE. `rsp_rdata` holds its value until the next access.
- No response backpressure. The consumer must sample `rsp_valid`/`rsp_rdata` in the RESP cycle.
- Address bits above `ADDR_W+1` are ignored; addresses wrap modulo 2^ADDR_W words.
- `req_*` inputs are don't-care outside IDLE. Changes while busy have no effect.
- The memory array is not reset. Reading a never-written word returns undefined data.

## Timing
- Reset values:
  - state = IDLE
  - `req_ready`=1
  - `rsp_valid`=0
  - `rsp_rdata`=0
  - `rsp_err`=0
  - `busy`=0
  - `cnt`=0
- Let handshake edge = E0:
  - access edge = E(WAIT_CYCLES+1).
  - `rsp_valid` is high in the cycle after that edge, so WAIT_CYCLES+1 cycles after E0.
- Throughput: one request per WAIT_CYCLES+3 cycles. `req_ready` rises again in the cycle after RESP.
- `busy` = (state≠IDLE). It is registered state, so there is no combinational path from `req_valid`.
- Reset mid-operation: asynchronous return to IDLE, all outputs at their reset values.
  - A store whose access edge has not occurred is discarded.
  - A store already written stays written.
- A store followed by a load to the same word returns the new data (accesses are serialised).

## Configuration
- Macro `DMEM_ALIGN_CHECK_EN`.
- Defined:
  - A request with `req_addr[1:0]`≠0 still takes the full latency.
  - At the access edge, no write occurs and `rsp_rdata`←0.
  - `rsp_err`=1 during the RESP cycle, 0 otherwise.
- Undefined:
  - `req_addr[1:0]` is ignored and the access proceeds on the word index.
  - `rsp_err` is tied 0.
  - The port exists in both builds.

## Test plan
- Reset, then idle for 3 cycles -> `req_ready`=1, `busy`=0, `rsp_valid`=0, `rsp_rdata`=0.
- With WAIT_CYCLES=1:
  - Store addr 0x10, data 0xDEADBEEF -> `rsp_valid` 2 cycles after handshake, `rsp_rdata`=0xDEADBEEF.
  - Then load addr 0x10 -> `rsp_rdata`=0xDEADBEEF.
- With WAIT_CYCLES=0:
  - Back-to-back stores to addr 0x00 (value 1) and 0x3FC (value 2), holding `req_valid` high.
  - Second request is accepted exactly 3 cycles after the first.
  - Loads then return 1 and 2.
- With ADDR_W=8:
  - Store 0x55 to addr 0x400 (wraps to word 0), then load addr 0x000 -> 0x55.
- Store to addr 0x20 with value 0xA, then assert `rst` in the WAIT cycle with WAIT_CYCLES=3, then load addr 0x20:
  - Prior value is returned; no `rsp_valid` for the aborted store.
- With the macro defined:
  - Store 0x77 to addr 0x21 -> `rsp_err`=1, `rsp_rdata`=0.
  - Load addr 0x20 -> old value, not 0x77.
- With the macro undefined, the same sequence -> `rsp_err`=0 and the load returns 0x77.
